// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory stalls, exceptions,
// taken branches and load-use hazards, with a memory watchdog and saturating counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR    = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_ADDR-1:0] id_rs,
    input  logic [REG_ADDR-1:0] id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                ex_mem_read,
    input  logic [REG_ADDR-1:0] ex_rd,
    input  logic                ex_branch_taken,
    input  logic                mem_busy,
    input  logic                exc_req,
    output logic                pc_freeze,
    output logic                pc_exc_sel,
    output logic                if_id_freeze,
    output logic                if_id_flush,
    output logic                id_ex_freeze,
    output logic                id_ex_flush,
    output logic                ex_mem_freeze,
    output logic                ex_mem_flush,
    output logic                mem_wb_flush,
    output logic                mem_timeout,
    output logic [CNT_W-1:0]    stall_count,
    output logic [CNT_W-1:0]    flush_count
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    logic            exc_pend;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_cnt_next;
    logic            rs_hit;
    logic            rt_hit;
    logic            load_use;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign rs_hit   = id_use_rs && (id_rs == ex_rd);
    assign rt_hit   = id_use_rt && (id_rt == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs_hit || rt_hit);

    always_comb begin
        pc_freeze     = 1'b0;
        pc_exc_sel    = 1'b0;
        if_id_freeze  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_freeze  = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_freeze = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_flush  = 1'b0;
        if (mem_busy) begin
            pc_freeze     = 1'b1;
            if_id_freeze  = 1'b1;
            id_ex_freeze  = 1'b1;
            ex_mem_freeze = 1'b1;
            mem_wb_flush  = 1'b1;
        end else if (exc_req || exc_pend) begin
            pc_exc_sel    = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
            mem_wb_flush  = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (load_use) begin
            pc_freeze     = 1'b1;
            if_id_freeze  = 1'b1;
            id_ex_flush   = 1'b1;
        end
    end

    always_comb begin
        wait_cnt_next = wait_cnt;
        if (!mem_busy) begin
            wait_cnt_next = '0;
        end else if (wait_cnt != WC_MAX) begin
            wait_cnt_next = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_pend    <= 1'b0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            // An exception arriving during a stall is held until the stall ends.
            exc_pend <= mem_busy ? (exc_pend | exc_req) : 1'b0;
            wait_cnt <= wait_cnt_next;
            if (wait_cnt_next == WC_MAX) begin
                mem_timeout <= 1'b1;
            end
            if (pc_freeze && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (if_id_flush && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
endmodule
